kb_text_ctrl: RTL

//  Controller between the PS/2 scan-code receiver and the text frame buffer. Consumes
//  set-2 scan bytes (synchronised one-cycle strobes), tracks break/extended prefixes,

---
 rtl/kb_text_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/kb_text_ctrl.sv
// Purpose: turns PS/2 set-2 scan bytes into cursor moves and text frame-buffer writes, with an Esc clear sweep.
// Latency: one cycle from an accepted scan byte to the write strobe/cursor update; the sweep takes ROWS*COLS cycles.
// Backpressure: none upstream; scan bytes that arrive while busy is high are dropped.
module kb_text_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [7:0]        code,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic              busy,
  output logic [7:0]        last_char
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXTBRK,
    S_CLEAR
  } state_t;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ROWS * COLS - 1);
  localparam logic [7:0]        SPACE    = 8'h20;

  state_t            state, state_n;
  logic [ROW_W-1:0]  row_n;
  logic [COL_W-1:0]  col_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              busy_n;
  logic [7:0]        last_n;
  logic [7:0]        ascii;
  logic [ROW_W-1:0]  row_inc;
  logic [ROW_W-1:0]  bs_row;
  logic [COL_W-1:0]  bs_col;

  // Scan code to ASCII for printable keys; 0x00 means "not printable".
  function automatic logic [7:0] to_ascii(input logic [7:0] sc);
    case (sc)
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
      8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
      8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
      8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
      8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
      8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
      8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      8'h29: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Linear frame-buffer address of a cursor position.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // State, cursor and write port are all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_row   <= '0;
      cur_col   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      last_char <= '0;
    end else begin
      state     <= state_n;
      cur_row   <= row_n;
      cur_col   <= col_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      busy      <= busy_n;
      last_char <= last_n;
    end
  end

  // Prefix tracking, key actions and the clear sweep.
  always_comb begin
    state_n   = state;
    row_n     = cur_row;
    col_n     = cur_col;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    busy_n    = busy;
    last_n    = last_char;
    ascii     = to_ascii(code);
    row_inc   = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    bs_row    = cur_row;
    bs_col    = cur_col;

    case (state)
      S_IDLE: begin
        if (code_valid) begin
          case (code)
            8'hF0: state_n = S_BRK;
            8'hE0: state_n = S_EXT;
            8'h76: begin
              // Sweep starts with address 0 on the very next cycle.
              state_n   = S_CLEAR;
              busy_n    = 1'b1;
              wr_en_n   = 1'b1;
              wr_addr_n = '0;
              wr_data_n = SPACE;
            end
            8'h5A: begin
              col_n = '0;
              row_n = row_inc;
            end
            8'h66: begin
              // Step back one cell and blank it; top-left corner is a no-op.
              if (cur_col != '0 || cur_row != '0) begin
                if (cur_col != '0) begin
                  bs_col = cur_col - COL_W'(1);
                end else begin
                  bs_col = COL_LAST;
                  bs_row = cur_row - ROW_W'(1);
                end
                row_n     = bs_row;
                col_n     = bs_col;
                wr_en_n   = 1'b1;
                wr_addr_n = addr_of(bs_row, bs_col);
                wr_data_n = SPACE;
              end
            end
            default: begin
              if (ascii != 8'h00) begin
                wr_en_n   = 1'b1;
                wr_addr_n = addr_of(cur_row, cur_col);
                wr_data_n = ascii;
                last_n    = ascii;
                if (cur_col == COL_LAST) begin
                  col_n = '0;
                  row_n = row_inc;
                end else begin
                  col_n = cur_col + COL_W'(1);
                end
              end
            end
          endcase
        end
      end
      S_BRK: begin
        if (code_valid) state_n = S_IDLE;
      end
      S_EXT: begin
        if (code_valid) begin
          state_n = S_IDLE;
          case (code)
            8'hF0: state_n = S_EXTBRK;
            8'h6B: if (cur_col != '0)       col_n = cur_col - COL_W'(1);
            8'h74: if (cur_col != COL_LAST) col_n = cur_col + COL_W'(1);
            8'h75: if (cur_row != '0)       row_n = cur_row - ROW_W'(1);
            8'h72: if (cur_row != ROW_LAST) row_n = cur_row + ROW_W'(1);
            default: ;
          endcase
        end
      end
      S_EXTBRK: begin
        if (code_valid) state_n = S_IDLE;
      end
      S_CLEAR: begin
        // Input is ignored here; wr_addr doubles as the sweep pointer.
        if (wr_addr == CLR_LAST) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          row_n   = '0;
          col_n   = '0;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = wr_addr + ADDR_W'(1);
          wr_data_n = SPACE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
